// File: rtl/timer_status_pkg.sv
// timer_status_pkg: shared register width and TSR bit positions for the timer status block.
package timer_status_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int TSR_OVF_BIT = 0;
  localparam int TSR_UDF_BIT = 1;
  localparam int TSR_ORN_BIT = 2;
endpackage

// File: rtl/timer_status_edge_detect.sv
// edge_detect: 1-bit rising-edge detector against a registered copy, synchronous reset.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic q;
  always_ff @(posedge clk)
    q <= rst ? 1'b0 : d;
  assign pulse = d & ~q;
endmodule

// File: rtl/timer_status.sv
// timer_status: sticky OVF/UDF/ORN status register with write-0-to-clear; optional irq under TIMER_STATUS_IRQ_EN.
module timer_status import timer_status_pkg::*; #(
  parameter int DATA_WIDTH = timer_status_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tmr_ovf,
  input  logic                  tmr_udf,
  input  logic                  tsr_we,
  input  logic [DATA_WIDTH-1:0] tsr_wdata,
  input  logic                  ovf_ie,
  input  logic                  udf_ie,
  output logic [DATA_WIDTH-1:0] tsr,
  output logic                  irq
);
  logic ovf_ev, udf_ev;
  logic [2:0] flags, clr, set;
  edge_detect u_ovf (.clk(clk), .rst(rst), .d(tmr_ovf), .pulse(ovf_ev));
  edge_detect u_udf (.clk(clk), .rst(rst), .d(tmr_udf), .pulse(udf_ev));
  assign clr = tsr_we ? ~tsr_wdata[2:0] : 3'b000;
  always_comb begin
    set = 3'b000;
    set[TSR_OVF_BIT] = ovf_ev;
    set[TSR_UDF_BIT] = udf_ev;
    set[TSR_ORN_BIT] = (ovf_ev & flags[TSR_OVF_BIT]) | (udf_ev & flags[TSR_UDF_BIT]);
  end
  // set beats a same-cycle software clear
  always_ff @(posedge clk)
    flags <= rst ? 3'b000 : set | (flags & ~clr);
  assign tsr = {{(DATA_WIDTH-3){1'b0}}, flags};
`ifdef TIMER_STATUS_IRQ_EN
  always_ff @(posedge clk)
    irq <= rst ? 1'b0 : (flags[TSR_OVF_BIT] & ovf_ie) | (flags[TSR_UDF_BIT] & udf_ie);
  logic unused;
  assign unused = ^tsr_wdata[DATA_WIDTH-1:3];
`else
  assign irq = 1'b0;
  logic unused;
  assign unused = ^{ovf_ie, udf_ie, tsr_wdata[DATA_WIDTH-1:3]};
`endif
endmodule

// File: doc/timer_status.md
TIMER_STATUS -- requirements
Module: timer_status

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the register width; only bits [2:0] of tsr carry function.
REQ-002 The block SHALL have port clk, input, 1, the single clock; every flop is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-004 The block SHALL have port tmr_ovf, input, 1, the counter overflow indication; it is a level that may stay high for several cycles.
REQ-005 The block SHALL have port tmr_udf, input, 1, the counter underflow indication; it is a level that may stay high for several cycles.
REQ-006 The block SHALL have port tsr_we, input, 1, the single-cycle software write strobe for TSR.
REQ-007 The block SHALL have port tsr_wdata, input, DATA_WIDTH, the software write data for TSR.
REQ-008 The block SHALL have port ovf_ie, input, 1, the overflow interrupt enable.
REQ-009 The block SHALL have port udf_ie, input, 1, the underflow interrupt enable.
REQ-010 The block SHALL have port tsr, output, DATA_WIDTH, the Timer Status Register: bit 0 OVF, bit 1 UDF, bit 2 ORN (overrun), bits [7:3] read 0.
REQ-011 The block SHALL have port irq, output, 1, the registered timer interrupt request.

Function
REQ-012 Each event input SHALL be rising-edge detected against a registered copy; an event is detected in the cycle where the input is 1 and its registered copy is 0.
REQ-013 A detected OVF event SHALL set tsr[0] on the next clock edge; a detected UDF event SHALL set tsr[1] on the next clock edge. Latency is 1 cycle from the input edge to the flag.
REQ-014 Flags SHALL be sticky: they hold until software clears them.
REQ-015 A write with tsr_we=1 and tsr_wdata[n]=0 SHALL clear flag n for n in 0..2; writing 1 to a flag SHALL have no effect; writing bits [7:3] SHALL have no effect.
REQ-016 If a set and a software clear of the same flag occur in the same cycle, the set SHALL win and the flag SHALL be 1.
REQ-017 If an event is detected while its flag is already 1, tsr[2] ORN SHALL be set; ORN is cleared only by software, under REQ-015.
REQ-018 If OVF and UDF events are detected in the same cycle, both flags SHALL set.
REQ-019 A level held high on an event input SHALL produce exactly one set; a new set requires the input to go low and then high again.
REQ-020 The unused tsr bits [DATA_WIDTH-1:3] SHALL be constant 0.

Reset
REQ-021 While rst=1 on a clock edge, tsr SHALL become 0, irq SHALL become 0, and both edge-detect registers SHALL become 0.
REQ-022 An event input that is high when reset is released SHALL be detected as an edge on the first cycle after reset.
REQ-023 A reset asserted mid-operation SHALL discard pending flags and suppress irq from the next edge.

Configuration
REQ-024 With the macro TIMER_STATUS_IRQ_EN defined, irq SHALL be registered as (tsr[0]&ovf_ie)|(tsr[1]&udf_ie), updated one cycle after the flags change.
REQ-025 Without TIMER_STATUS_IRQ_EN, irq SHALL be tied to 0, ovf_ie and udf_ie SHALL be ignored, and no irq flop SHALL exist.

Structure
REQ-026 The following SHALL live in the shared reg_def package/header: the TSR bit indices (TSR_OVF_BIT=0, TSR_UDF_BIT=1, TSR_ORN_BIT=2) and DATA_WIDTH.
REQ-027 The block SHALL instantiate one sub-module, edge_detect (1-bit rising-edge detector with synchronous reset), once per event input.
REQ-028 The block SHALL contain no combinational path from any input to tsr.

Verification
REQ-029 The bench SHALL cover this scenario: tmr_ovf pulses 1 cycle at cycle 10 -> tsr=0x01 from cycle 11; with the IRQ macro and ovf_ie=1, irq=1 from cycle 12.
REQ-030 The bench SHALL cover this scenario: tmr_udf held high for 5 cycles -> tsr=0x02, ORN stays 0; a write of tsr_wdata=0xFD then gives tsr=0x00.
REQ-031 The bench SHALL cover this scenario: tmr_ovf rises in the same cycle as a write of tsr_wdata=0xFE while OVF=1 -> OVF stays 1 and ORN=1, so tsr=0x05.
REQ-032 The bench SHALL cover this scenario: tmr_ovf and tmr_udf rise together -> tsr=0x03; with ovf_ie=0 and udf_ie=1, irq=1.
REQ-033 The bench SHALL cover this scenario: flags set to tsr=0x07, then rst=1 for 1 cycle -> tsr=0x00 and irq=0 on the next edge; a tmr_ovf still high after reset is released sets OVF once.
REQ-034 The bench SHALL cover this scenario: a write of tsr_wdata=0xFF while tsr=0x03 -> tsr stays 0x03.
